// File: rtl/alu_accumulator_ctrl_if.sv
// Command handshake bundle for alu_accumulator_ctrl: a producer drives the command fields,
// the controller answers with cmd_ready.
interface alu_accumulator_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int REP_W = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_cin;
  logic [REP_W-1:0] cmd_rep;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_b, cmd_cin, cmd_rep,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_b, cmd_cin, cmd_rep,
    output cmd_ready
  );
endinterface

// File: rtl/alu_accumulator_ctrl.sv
// Accumulator/sequencer around an external combinational ALU: latches a command, feeds the
// accumulator back as operand A for cmd_rep+1 cycles, then pulses done.
module alu_accumulator_ctrl #(
  parameter int WIDTH = 4,
  parameter int REP_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_accumulator_ctrl_if.slave   cmd,
  output logic                    alu_sel0,
  output logic                    alu_sel1,
  output logic                    alu_sel2,
  output logic                    alu_sel3,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic                    alu_cin,
  input  logic [WIDTH-1:0]        alu_f,
  input  logic                    alu_cout,
  output logic [WIDTH-1:0]        acc,
  output logic                    flag_c,
  output logic                    flag_z,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] cnt;

  assign cmd.cmd_ready = (state == IDLE);

  assign {alu_sel3, alu_sel2, alu_sel1, alu_sel0} = op_q;
  assign alu_a   = acc;
  assign alu_b   = b_q;
  assign alu_cin = cin_q;

  // cnt is compared before incrementing, so rep=all-ones runs 2**REP_W times without wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      rep_q  <= '0;
      cnt    <= '0;
      acc    <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd.cmd_valid) begin
            op_q  <= cmd.cmd_op;
            b_q   <= cmd.cmd_b;
            cin_q <= cmd.cmd_cin;
            rep_q <= cmd.cmd_rep;
            cnt   <= '0;
            if (cmd.cmd_load) begin
              acc    <= cmd.cmd_b;
              flag_z <= (cmd.cmd_b == '0);
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= EXEC;
            end
          end
        end
        EXEC: begin
          acc    <= alu_f;
          flag_z <= (alu_f == '0);
          if (op_q[3:2] == 2'b00) begin
            flag_c <= alu_cout;
          end
          if (cnt == rep_q) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt   <= cnt + REP_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_accumulator_ctrl.sv
// Self-checking bench for alu_accumulator_ctrl: a behavioural 4-bit ALU closes the loop,
// and a command-level model predicts results, latency and ready/done timing.
module tb_alu_accumulator_ctrl;

  logic       clk;
  logic       rst;
  logic       alu_sel0, alu_sel1, alu_sel2, alu_sel3;
  logic [3:0] alu_a, alu_b, alu_f;
  logic       alu_cin, alu_cout;
  logic [3:0] acc;
  logic       flag_c, flag_z, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [3:0] m_acc, m_b, m_op;
  logic       m_c, m_z, m_cin;
  int         accept_cycle, done_cycle;

  alu_accumulator_ctrl_if #(.WIDTH(4), .REP_W(2)) cmd_if ();

  alu_accumulator_ctrl #(.WIDTH(4), .REP_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_if.slave),
    .alu_sel0 (alu_sel0),
    .alu_sel1 (alu_sel1),
    .alu_sel2 (alu_sel2),
    .alu_sel3 (alu_sel3),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_f    (alu_f),
    .alu_cout (alu_cout),
    .acc      (acc),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .done     (done)
  );

  // Reference ALU: 00xx arithmetic, 01xx logic, 10xx shift left, 11xx shift right
  function automatic logic [4:0] aluFn(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic cin);
    logic [4:0] r;
    r = 5'd0;
    case (op[3:2])
      2'b00: case (op[1:0])
        2'b00:   r = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        2'b01:   r = {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
        2'b10:   r = {1'b0, a} + {4'd0, cin};
        default: r = {1'b0, a} + 5'h0F + {4'd0, cin};
      endcase
      2'b01: case (op[1:0])
        2'b00:   r = {1'b0, a & b};
        2'b01:   r = {1'b0, a | b};
        2'b10:   r = {1'b0, a ^ b};
        default: r = {1'b0, ~a};
      endcase
      2'b10:   r = {a[3], a[2:0], 1'b0};
      default: r = {a[0], 1'b0, a[3:1]};
    endcase
    return r;
  endfunction

  always_comb begin
    {alu_cout, alu_f} = aluFn({alu_sel3, alu_sel2, alu_sel1, alu_sel0}, alu_a, alu_b, alu_cin);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Per-cycle comparison against the command-level model; acc is unknown mid-command
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("cmd_ready", int'(cmd_if.cmd_ready), int'(cyc > done_cycle));
      checkOutput("done", int'(done), int'(cyc == done_cycle));
      checkOutput("alu_sel", int'({alu_sel3, alu_sel2, alu_sel1, alu_sel0}), int'(m_op));
      checkOutput("alu_b", int'(alu_b), int'(m_b));
      checkOutput("alu_cin", int'(alu_cin), int'(m_cin));
      if (!(cyc >= accept_cycle && cyc < done_cycle)) begin
        checkOutput("acc", int'(acc), int'(m_acc));
        checkOutput("flag_c", int'(flag_c), int'(m_c));
        checkOutput("flag_z", int'(flag_z), int'(m_z));
      end
    end
  end

  task automatic modelReset();
    m_acc = 4'd0; m_c = 1'b0; m_z = 1'b0;
    m_op = 4'd0; m_b = 4'd0; m_cin = 1'b0;
    accept_cycle = -10;
    done_cycle = -10;
  endtask

  // Drive one cycle of command inputs; the command is taken at the next edge only if idle
  task automatic applyStimulus(input logic v, input logic ld, input logic [3:0] op,
                               input logic [3:0] b, input logic c, input logic [1:0] rep,
                               output logic accepted);
    logic [4:0] r;
    @(negedge clk);
    #1;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_load  = ld;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_b     = b;
    cmd_if.cmd_cin   = c;
    cmd_if.cmd_rep   = rep;
    accepted = v && !rst && (cyc > done_cycle);
    if (accepted) begin
      accept_cycle = cyc + 1;
      m_op = op; m_b = b; m_cin = c;
      if (ld) begin
        m_acc = b;
        m_z = (b == 4'd0);
        done_cycle = accept_cycle;
      end else begin
        for (int i = 0; i <= int'(rep); i++) begin
          r = aluFn(op, m_acc, b, c);
          m_acc = r[3:0];
          m_z = (r[3:0] == 4'd0);
          if (op[3:2] == 2'b00) m_c = r[4];
        end
        done_cycle = accept_cycle + int'(rep) + 1;
      end
    end
  endtask

  task automatic acceptOnly(input logic ld, input logic [3:0] op, input logic [3:0] b,
                            input logic c, input logic [1:0] rep);
    logic got;
    int tries;
    got = 1'b0;
    tries = 0;
    while (!got && tries < 20) begin
      applyStimulus(1'b1, ld, op, b, c, rep, got);
      tries++;
    end
    if (!got) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("[TB] FAIL accept_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic issueCommand(input logic ld, input logic [3:0] op, input logic [3:0] b,
                              input logic c, input logic [1:0] rep, output int lat);
    logic dummy;
    logic seen;
    acceptOnly(ld, op, b, c, rep);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      applyStimulus(1'b0, ld, op, b, c, rep, dummy);
      lat++;
      seen = done;
    end
  endtask

  task automatic resetPulse();
    @(posedge clk);
    #2;
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    modelReset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int n_acc;
    int done_seen;
    logic got;
    logic [3:0] bval;

    modelReset();
    rst = 1'b1;
    // a load presented during reset must be ignored
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_load  = 1'b1;
    cmd_if.cmd_op    = 4'd0;
    cmd_if.cmd_b     = 4'hF;
    cmd_if.cmd_cin   = 1'b0;
    cmd_if.cmd_rep   = 2'd0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, got);
    checkOutput("reset_acc", int'(acc), 0);
    checkOutput("reset_ready", int'(cmd_if.cmd_ready), 1);

    // reset in the middle of a 4x shift left
    issueCommand(1'b1, 4'b0000, 4'b0001, 1'b0, 2'd0, lat);
    acceptOnly(1'b0, 4'b1000, 4'b0000, 1'b0, 2'd3);
    repeat (2) applyStimulus(1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0, 2'd3, got);
    resetPulse();
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, got);
      if (done) done_seen++;
    end
    checkOutput("abort_done_pulses", done_seen, 0);
    checkOutput("abort_acc", int'(acc), 0);
    checkOutput("abort_flags", int'({flag_c, flag_z}), 0);
    checkOutput("abort_ready", int'(cmd_if.cmd_ready), 1);

    // load 0100 then A+B with B=0010
    issueCommand(1'b1, 4'b0000, 4'b0100, 1'b0, 2'd0, lat);
    checkOutput("load_latency", lat, 1);
    issueCommand(1'b0, 4'b0000, 4'b0010, 1'b0, 2'd0, lat);
    checkOutput("add_latency", lat, 2);
    checkOutput("add_acc", int'(acc), 6);
    checkOutput("add_z", int'(flag_z), 0);

    // 1111+0001 sets carry; shifts afterwards must leave it alone
    issueCommand(1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, lat);
    issueCommand(1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0, lat);
    checkOutput("ovf_acc", int'(acc), 0);
    checkOutput("ovf_c", int'(flag_c), 1);
    checkOutput("ovf_z", int'(flag_z), 1);
    issueCommand(1'b1, 4'b0000, 4'b0001, 1'b0, 2'd0, lat);
    issueCommand(1'b0, 4'b1000, 4'b0000, 1'b0, 2'd2, lat);
    checkOutput("shl_latency", lat, 4);
    checkOutput("shl_acc", int'(acc), 8);
    checkOutput("shl_c_held", int'(flag_c), 1);

    // full 2**REP_W iterations of shift right
    issueCommand(1'b1, 4'b0000, 4'b1100, 1'b0, 2'd0, lat);
    issueCommand(1'b0, 4'b1100, 4'b0000, 1'b0, 2'd3, lat);
    checkOutput("shr_latency", lat, 5);
    checkOutput("shr_acc", int'(acc), 0);
    checkOutput("shr_z", int'(flag_z), 1);

    // AND then OR against 0010
    issueCommand(1'b1, 4'b0000, 4'b0100, 1'b0, 2'd0, lat);
    issueCommand(1'b0, 4'b0100, 4'b0010, 1'b0, 2'd0, lat);
    checkOutput("and_acc", int'(acc), 0);
    checkOutput("and_z", int'(flag_z), 1);
    issueCommand(1'b0, 4'b0101, 4'b0010, 1'b0, 2'd0, lat);
    checkOutput("or_acc", int'(acc), 2);
    checkOutput("or_z", int'(flag_z), 0);

    // cmd_valid held high with B changing every cycle: only idle-cycle values count
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      bval = 4'(i + 1);
      applyStimulus(1'b1, 1'b0, 4'b0000, bval, 1'b0, 2'd0, got);
      if (got) n_acc++;
    end
    repeat (4) applyStimulus(1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 2'd0, got);
    checkOutput("stream_accepts", n_acc, 4);
    checkOutput("stream_acc", int'(acc), 8);
    checkOutput("stream_c", int'(flag_c), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
